// File: rtl/fpmul_seq_ctrl.sv
// fpmul_seq_ctrl: sequential IEEE-754 single multiplier with a valid/ready front end,
// shift-add mantissa datapath retiring BITS_PER_CYC multiplier bits per cycle.
module fpmul_seq_ctrl #(
  parameter int BITS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic [2:0]  flags,
  output logic        busy
);
  localparam int ITER = 24 / BITS_PER_CYC;
  localparam logic [2:0] IDLE = 3'd0, EXP = 3'd1, MUL = 3'd2, NORM = 3'd3, DONE = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, product_q, product_d;
  logic [2:0]  flags_q, flags_d;
  logic [9:0]  exp_q, exp_d;
  logic [23:0] mb_q, mb_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [47:0] pp;
  logic [5:0]  sh;
  logic [9:0]  en;
  logic [22:0] mant;
  logic        s, nan_in, zero_in;
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    flags_d   = flags_q;
    exp_d     = exp_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    s         = a_q[31] ^ b_q[31];
    nan_in    = (&input_a[30:23]) | (&input_b[30:23]);
    zero_in   = (~|input_a[30:23]) | (~|input_b[30:23]);
    pp        = 48'({1'b1, a_q[22:0]}) * 48'(mb_q[BITS_PER_CYC-1:0]);
    sh        = 6'(int'(cnt_q) * BITS_PER_CYC);
    en        = exp_q + {9'b0, acc_q[47]};
    mant      = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d       = input_a;
        b_d       = input_b;
        flags_d   = nan_in ? 3'b100 : 3'b000;
        product_d = nan_in ? 32'h7FC0_0000 : zero_in ? {input_a[31] ^ input_b[31], 31'b0} : product_q;
        state_d   = (nan_in || zero_in) ? DONE : EXP;
      end
      EXP: begin
        exp_d   = {2'b0, a_q[30:23]} + {2'b0, b_q[30:23]} - 10'd127;
        mb_d    = {1'b1, b_q[22:0]};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        acc_d   = acc_q + (pp << sh);
        mb_d    = mb_q >> BITS_PER_CYC;
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(ITER - 1)) ? NORM : MUL;
      end
      NORM: begin
        // en is signed: overflow and underflow are checked on the two's-complement value
        product_d = ($signed(en) >= 10'sd255) ? {s, 8'hFF, 23'b0} :
                    ($signed(en) <= 10'sd0)   ? {s, 31'b0} : {s, en[7:0], mant};
        flags_d   = ($signed(en) >= 10'sd255) ? 3'b010 : ($signed(en) <= 10'sd0) ? 3'b001 : 3'b000;
        state_d   = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      flags_q   <= '0;
      exp_q     <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      flags_q   <= flags_d;
      exp_q     <= exp_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign product   = product_q;
  assign flags     = flags_q;
endmodule
